// File: rtl/data_cache_responder.sv
// data_cache_responder
//   MEM-stage responder: direct-mapped, write-through, no-write-allocate word
//   cache (one 32-bit word per line) in front of a slow backing word store.
//   A read miss raises memError (the core stalls on it) for one IDLE cycle
//   plus MISS_LAT FILL cycles; the held read then completes as a hit.
//
//   Optional feature macro: DMEM_STATS_EN (read hit/miss counters).
//
//   Parameters: LINES (cache lines, pow2 >= 2), WORDS (backing depth, pow2
//               >= LINES), MISS_LAT (backing read latency, >= 1).
//   Ports:
//     Clk        rising-edge clock
//     Rst        asynchronous active-low reset
//     Address    byte address; bits [1:0] and bits above the word index ignored
//     WriteData  store data
//     memWrite   store request (wins over memRead)
//     memRead    load request
//     DO         load data, combinational, 0 unless a read hit
//     memError   busy/miss; requester holds its request while high
//     hitCount   read hits completed (0 without DMEM_STATS_EN)
//     missCount  fills started (0 without DMEM_STATS_EN)
//     dbg_state  FSM state (0 = IDLE, 1 = FILL)
//
//   Handshake: a request is accepted on the rising edge of any cycle in which
//   it is presented with memError low; while memError is high the requester
//   keeps the request stable and nothing is accepted.
module data_cache_responder #(
  parameter int LINES    = 16,
  parameter int WORDS    = 256,
  parameter int MISS_LAT = 4
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        memWrite,
  input  logic        memRead,
  output logic [31:0] DO,
  output logic        memError,
  output logic [31:0] hitCount,
  output logic [31:0] missCount,
  output logic        dbg_state
);

  localparam int IDX_W  = $clog2(LINES);
  localparam int WIDX_W = $clog2(WORDS);
  localparam int CNT_W  = (MISS_LAT > 1) ? $clog2(MISS_LAT) : 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] FILL = 1'b1;

  logic [0:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [WIDX_W-1:0] fill_word;

  logic [31:0]       backing   [WORDS];
  logic [31:0]       line_data [LINES];
  // Each line remembers the full word index it holds; comparing it against
  // the request's word index is the same as comparing valid tags.
  logic [WIDX_W-1:0] line_word [LINES];
  logic [LINES-1:0]  line_valid;

  logic [WIDX_W-1:0] word;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  fill_idx;
  logic              is_idle;
  logic              rd_req;
  logic              tag_hit;
  logic              hit;
  logic              start_fill;
  logic              wr_en;
  logic              fill_done;
  logic              unused_addr;

  assign word        = Address[WIDX_W+1:2];
  assign idx         = word[IDX_W-1:0];
  assign fill_idx    = fill_word[IDX_W-1:0];
  assign unused_addr = ^{Address[31:WIDX_W+2], Address[1:0]};

  // A simultaneous read+write is a write, so it never counts as a read.
  assign is_idle    = (state == IDLE);
  assign rd_req     = memRead & ~memWrite;
  assign tag_hit    = line_valid[idx] & (line_word[idx] == word);
  assign hit        = is_idle & rd_req & tag_hit;
  assign start_fill = is_idle & rd_req & ~tag_hit;
  // Writes arriving during FILL are simply not accepted until IDLE.
  assign wr_en      = is_idle & memWrite;
  assign fill_done  = (state == FILL) && (cnt == '0);

  assign DO        = hit ? line_data[idx] : 32'd0;
  assign memError  = ~is_idle | start_fill;
  assign dbg_state = state;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state     <= IDLE;
      cnt       <= '0;
      fill_word <= '0;
    end else if (start_fill) begin
      state     <= FILL;
      cnt       <= CNT_W'(MISS_LAT - 1);
      fill_word <= word;
    end else if (fill_done) begin
      state <= IDLE;
    end else if (state == FILL) begin
      cnt <= cnt - 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      line_valid <= '0;
      for (int k = 0; k < WORDS; k++) backing[k] <= '0;
      for (int k = 0; k < LINES; k++) begin
        line_data[k] <= '0;
        line_word[k] <= '0;
      end
    end else begin
      // Fill and write are mutually exclusive: fills complete in FILL,
      // writes are accepted only in IDLE.
      if (fill_done) begin
        line_data[fill_idx]  <= backing[fill_word];
        line_word[fill_idx]  <= fill_word;
        line_valid[fill_idx] <= 1'b1;
      end
      if (wr_en) begin
        backing[word] <= WriteData;
        if (tag_hit) line_data[idx] <= WriteData;
      end
    end
  end

`ifdef DMEM_STATS_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (hit)        hit_cnt  <= hit_cnt + 32'd1;
      if (start_fill) miss_cnt <= miss_cnt + 32'd1;
    end
  end

  assign hitCount  = hit_cnt;
  assign missCount = miss_cnt;
`else
  assign hitCount  = 32'd0;
  assign missCount = 32'd0;
`endif

endmodule
